// File: rtl/regfile_rename_pkg.sv
// regfile_rename_pkg: shared constants for the renamed register file
package regfile_rename_pkg;
  localparam logic rstEnable = 1'b0;
  localparam logic rstDisable = 1'b1;
  localparam logic readEnable = 1'b1;
  localparam logic writeEnable = 1'b1;
  localparam logic [31:0] ZERO32 = 32'h0;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int TAG_W_DEF = 4;
endpackage

// File: rtl/regfile_rename_if.sv
// regfile_rename_if: read, issue, commit and flush bus of the renamed register file
interface regfile_rename_if
  import regfile_rename_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int TAG_W = TAG_W_DEF
);
  localparam int IDX_W = $clog2(NREGS);
  logic [NREAD-1:0] rdE_in;
  logic [NREAD*IDX_W-1:0] rdIdx_in;
  logic [NREAD*XLEN-1:0] rdData_out;
  logic [NREAD-1:0] rdBusy_out;
  logic [NREAD*TAG_W-1:0] rdTag_out;
  logic issueE_in;
  logic [IDX_W-1:0] issueIdx_in;
  logic [TAG_W-1:0] issueTag_in;
  logic commitE_in;
  logic [IDX_W-1:0] commitIdx_in;
  logic [TAG_W-1:0] commitTag_in;
  logic [XLEN-1:0] commitData_in;
  logic flush_in;
  logic [IDX_W:0] busyCount_out;
  modport master (
    output rdE_in, rdIdx_in, issueE_in, issueIdx_in, issueTag_in,
    output commitE_in, commitIdx_in, commitTag_in, commitData_in, flush_in,
    input rdData_out, rdBusy_out, rdTag_out, busyCount_out
  );
  modport slave (
    input rdE_in, rdIdx_in, issueE_in, issueIdx_in, issueTag_in,
    input commitE_in, commitIdx_in, commitTag_in, commitData_in, flush_in,
    output rdData_out, rdBusy_out, rdTag_out, busyCount_out
  );
endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one read port with reset/enable/x0 masking and same-cycle commit bypass
module regfile_read_port
  import regfile_rename_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int IDX_W = 5,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             rst_i,
  input  logic             rd_e_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [XLEN-1:0]  arr_data_i,
  input  logic             arr_busy_i,
  input  logic [TAG_W-1:0] arr_tag_i,
  input  logic             commit_e_i,
  input  logic [IDX_W-1:0] commit_idx_i,
  input  logic [TAG_W-1:0] commit_tag_i,
  input  logic [XLEN-1:0]  commit_data_i,
  output logic [XLEN-1:0]  rd_data_o,
  output logic             rd_busy_o,
  output logic [TAG_W-1:0] rd_tag_o
);
  logic kill, hit;
  always_comb begin
    kill = rst_i == rstEnable || rd_e_i != readEnable || rd_idx_i == '0;
    hit = commit_e_i == writeEnable && commit_idx_i == rd_idx_i;
    rd_data_o = kill ? '0 : hit ? commit_data_i : arr_data_i;
    rd_busy_o = kill ? 1'b0 : hit ? arr_busy_i && arr_tag_i != commit_tag_i : arr_busy_i;
    rd_tag_o = kill ? '0 : arr_tag_i;
  end
endmodule

// File: rtl/regfile_rename.sv
// regfile_rename: integer register file with per-register busy bit and ROB tag
module regfile_rename
  import regfile_rename_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic clk_in,
  input logic rst_in,
  regfile_rename_if.slave bus
);
  localparam int IDX_W = $clog2(NREGS);
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [TAG_W-1:0] tag_q [NREGS];
  logic [TAG_W-1:0] tag_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [IDX_W:0] cnt_q, cnt_d;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0] rd_busy;
  logic [NREAD*TAG_W-1:0] rd_tag;
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d = tag_q;
    if (bus.commitE_in == writeEnable && bus.commitIdx_in != '0) begin
      regs_d[bus.commitIdx_in] = bus.commitData_in;
      if (busy_q[bus.commitIdx_in] && tag_q[bus.commitIdx_in] == bus.commitTag_in)
        busy_d[bus.commitIdx_in] = 1'b0;
    end
    if (bus.flush_in)
      busy_d = '0;
    else if (bus.issueE_in == writeEnable && bus.issueIdx_in != '0) begin
      busy_d[bus.issueIdx_in] = 1'b1;
      tag_d[bus.issueIdx_in] = bus.issueTag_in;
    end
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) cnt_d = cnt_d + (IDX_W+1)'(busy_d[i]);
  end
  always_ff @(posedge clk_in)
    if (rst_in == rstEnable) begin
      regs_q <= '{default: '0};
      tag_q <= '{default: '0};
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q <= tag_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [IDX_W-1:0] idx;
    assign idx = bus.rdIdx_in[p*IDX_W +: IDX_W];
    regfile_read_port #(.XLEN(XLEN), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_port (
      .rst_i(rst_in),
      .rd_e_i(bus.rdE_in[p]),
      .rd_idx_i(idx),
      .arr_data_i(regs_q[idx]),
      .arr_busy_i(busy_q[idx]),
      .arr_tag_i(tag_q[idx]),
      .commit_e_i(bus.commitE_in),
      .commit_idx_i(bus.commitIdx_in),
      .commit_tag_i(bus.commitTag_in),
      .commit_data_i(bus.commitData_in),
      .rd_data_o(rd_data[p*XLEN +: XLEN]),
      .rd_busy_o(rd_busy[p]),
      .rd_tag_o(rd_tag[p*TAG_W +: TAG_W])
    );
  end
  assign bus.rdData_out = rd_data;
  assign bus.rdBusy_out = rd_busy;
  assign bus.rdTag_out = rd_tag;
  assign bus.busyCount_out = cnt_q;
endmodule
